// File: rtl/bank_sc_pkg.sv
// bank_sc_pkg: opcodes, FSM states and array geometry shared by bank_sc and its RAM.
package bank_sc_pkg;
    localparam int DATA_W = 128;
    localparam int DEPTH  = 128;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [2:0] OP_WRITE    = 3'd0;
    localparam logic [2:0] OP_READ     = 3'd1;
    localparam logic [2:0] OP_LINEFILL = 3'd2;
    typedef enum logic [2:0] {
        IDLE, WR0, WR1, RD0, RD1, RDW, RSP0, RSP1
    } state_t;
endpackage

// File: rtl/bank_sc_ram.sv
// bank_sc_ram: single-port synchronous data array with registered read data.
module bank_sc_ram
    import bank_sc_pkg::*;
(
    input  logic              clk_i,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/bank_sc.sv
// bank_sc: cache-bank data controller; writes/linefills two offsets, reads them back as two beats.
// Optional BANK_SC_PERF_CNT_EN adds saturating accepted-read/write counters.
module bank_sc
    import bank_sc_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              isu_sc_valid_i,
    output logic              isu_sc_ready_o,
    input  logic [1:0]        isu_sc_channel_id_i,
    input  logic [2:0]        isu_sc_opcode_i,
    input  logic [6:0]        isu_sc_set_way_offset_i,
    input  logic [7:0]        isu_sc_wbuffer_id_i,
    input  logic [2:0]        isu_sc_xbar_rob_num_i,
    input  logic [1:0]        isu_sc_cacheline_dirty_offset0_i,
    input  logic [1:0]        isu_sc_cacheline_dirty_offset1_i,
    input  logic [DATA_W-1:0] isu_sc_linefill_data_offset0_i,
    input  logic [DATA_W-1:0] isu_sc_linefill_data_offset1_i,
`ifdef BANK_SC_PERF_CNT_EN
    output logic [15:0]       sc_rd_cnt_o,
    output logic [15:0]       sc_wr_cnt_o,
`endif
    output logic              sc_xbar_valid_o,
    input  logic              sc_xbar_ready_i,
    output logic [1:0]        sc_xbar_channel_id_o,
    output logic [2:0]        sc_xbar_rob_num_o,
    output logic [7:0]        sc_xbar_wbuffer_id_o,
    output logic [DATA_W-1:0] sc_xbar_data_o,
    output logic              sc_xbar_last_o
);
    state_t            state_q;
    logic [2:0]        op_q;
    logic [5:0]        line_q;
    logic [1:0]        dirty0_q, dirty1_q, ch_q;
    logic [2:0]        rob_q;
    logic [7:0]        wb_q;
    logic [DATA_W-1:0] wd0_q, wd1_q, line0_q, line1_q, ram_rdata;
    logic              ram_we, accept, unused_swo0;

    assign unused_swo0 = isu_sc_set_way_offset_i[0];
    assign accept = isu_sc_valid_i && isu_sc_ready_o;
    // Offset1 is addressed only in the second beat of a write or read.
    assign ram_we = (state_q == WR0 && (op_q == OP_LINEFILL || dirty0_q != 2'b00)) ||
                    (state_q == WR1 && (op_q == OP_LINEFILL || dirty1_q != 2'b00));

    bank_sc_ram u_ram (
        .clk_i (clk_i),
        .we    (ram_we),
        .addr  ({line_q, state_q == WR1 || state_q == RD1}),
        .wdata (state_q == WR1 ? wd1_q : wd0_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q              <= IDLE;
            isu_sc_ready_o       <= 1'b0;
            sc_xbar_valid_o      <= 1'b0;
            sc_xbar_last_o       <= 1'b0;
            sc_xbar_channel_id_o <= '0;
            sc_xbar_rob_num_o    <= '0;
            sc_xbar_wbuffer_id_o <= '0;
            sc_xbar_data_o       <= '0;
`ifdef BANK_SC_PERF_CNT_EN
            sc_rd_cnt_o          <= '0;
            sc_wr_cnt_o          <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q           <= isu_sc_opcode_i;
                        line_q         <= isu_sc_set_way_offset_i[6:1];
                        dirty0_q       <= isu_sc_cacheline_dirty_offset0_i;
                        dirty1_q       <= isu_sc_cacheline_dirty_offset1_i;
                        wd0_q          <= isu_sc_linefill_data_offset0_i;
                        wd1_q          <= isu_sc_linefill_data_offset1_i;
                        ch_q           <= isu_sc_channel_id_i;
                        rob_q          <= isu_sc_xbar_rob_num_i;
                        wb_q           <= isu_sc_wbuffer_id_i;
                        isu_sc_ready_o <= 1'b0;
                        state_q        <= (isu_sc_opcode_i == OP_WRITE || isu_sc_opcode_i == OP_LINEFILL) ? WR0 :
                                          isu_sc_opcode_i == OP_READ ? RD0 : IDLE;
`ifdef BANK_SC_PERF_CNT_EN
                        if (isu_sc_opcode_i == OP_READ && sc_rd_cnt_o != 16'hFFFF)
                            sc_rd_cnt_o <= sc_rd_cnt_o + 16'd1;
                        if ((isu_sc_opcode_i == OP_WRITE || isu_sc_opcode_i == OP_LINEFILL) && sc_wr_cnt_o != 16'hFFFF)
                            sc_wr_cnt_o <= sc_wr_cnt_o + 16'd1;
`endif
                    end else begin
                        isu_sc_ready_o <= 1'b1;
                    end
                end
                WR0: state_q <= WR1;
                WR1: begin
                    state_q        <= IDLE;
                    isu_sc_ready_o <= 1'b1;
                end
                RD0: state_q <= RD1;
                RD1: begin
                    line0_q <= ram_rdata;
                    state_q <= RDW;
                end
                RDW: begin
                    line1_q              <= ram_rdata;
                    sc_xbar_valid_o      <= 1'b1;
                    sc_xbar_last_o       <= 1'b0;
                    sc_xbar_data_o       <= line0_q;
                    sc_xbar_channel_id_o <= ch_q;
                    sc_xbar_rob_num_o    <= rob_q;
                    sc_xbar_wbuffer_id_o <= wb_q;
                    state_q              <= RSP0;
                end
                RSP0: if (sc_xbar_ready_i) begin
                    sc_xbar_data_o <= line1_q;
                    sc_xbar_last_o <= 1'b1;
                    state_q        <= RSP1;
                end
                RSP1: if (sc_xbar_ready_i) begin
                    sc_xbar_valid_o <= 1'b0;
                    sc_xbar_last_o  <= 1'b0;
                    isu_sc_ready_o  <= 1'b1;
                    state_q         <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bank_sc.sv
// tb_bank_sc: directed vector table plus back-pressure and mid-response reset sequences for bank_sc.
module tb_bank_sc;
    import bank_sc_pkg::*;

    logic         clk_i = 1'b0, rst_i = 1'b0;
    logic         isu_sc_valid_i = 1'b0, isu_sc_ready_o;
    logic [1:0]   isu_sc_channel_id_i = '0;
    logic [2:0]   isu_sc_opcode_i = '0;
    logic [6:0]   isu_sc_set_way_offset_i = '0;
    logic [7:0]   isu_sc_wbuffer_id_i = '0;
    logic [2:0]   isu_sc_xbar_rob_num_i = '0;
    logic [1:0]   dirty0 = '0, dirty1 = '0;
    logic [127:0] wd0 = '0, wd1 = '0;
    logic         sc_xbar_valid_o, sc_xbar_ready_i = 1'b1, sc_xbar_last_o;
    logic [1:0]   sc_xbar_channel_id_o;
    logic [2:0]   sc_xbar_rob_num_o;
    logic [7:0]   sc_xbar_wbuffer_id_o;
    logic [127:0] sc_xbar_data_o;
`ifdef BANK_SC_PERF_CNT_EN
    logic [15:0]  sc_rd_cnt_o, sc_wr_cnt_o;
`endif

    bank_sc dut (
        .clk_i                            (clk_i),
        .rst_i                            (rst_i),
        .isu_sc_valid_i                   (isu_sc_valid_i),
        .isu_sc_ready_o                   (isu_sc_ready_o),
        .isu_sc_channel_id_i              (isu_sc_channel_id_i),
        .isu_sc_opcode_i                  (isu_sc_opcode_i),
        .isu_sc_set_way_offset_i          (isu_sc_set_way_offset_i),
        .isu_sc_wbuffer_id_i              (isu_sc_wbuffer_id_i),
        .isu_sc_xbar_rob_num_i            (isu_sc_xbar_rob_num_i),
        .isu_sc_cacheline_dirty_offset0_i (dirty0),
        .isu_sc_cacheline_dirty_offset1_i (dirty1),
        .isu_sc_linefill_data_offset0_i   (wd0),
        .isu_sc_linefill_data_offset1_i   (wd1),
`ifdef BANK_SC_PERF_CNT_EN
        .sc_rd_cnt_o                      (sc_rd_cnt_o),
        .sc_wr_cnt_o                      (sc_wr_cnt_o),
`endif
        .sc_xbar_valid_o                  (sc_xbar_valid_o),
        .sc_xbar_ready_i                  (sc_xbar_ready_i),
        .sc_xbar_channel_id_o             (sc_xbar_channel_id_o),
        .sc_xbar_rob_num_o                (sc_xbar_rob_num_o),
        .sc_xbar_wbuffer_id_o             (sc_xbar_wbuffer_id_o),
        .sc_xbar_data_o                   (sc_xbar_data_o),
        .sc_xbar_last_o                   (sc_xbar_last_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0, errors = 0;

    typedef struct {
        logic [2:0]   op;
        logic [6:0]   swo;
        logic [1:0]   dt0, dt1;
        logic [127:0] d0, d1;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // Returns one cycle after the acceptance edge (cycle T+1); inputs are then scrambled.
    task automatic send(input vec_t v, input logic [1:0] ch, input logic [2:0] rob, input logic [7:0] wb);
        int n = 0;
        while (!isu_sc_ready_o && n < 20) begin
            tick;
            n++;
        end
        chk("accept_ready", isu_sc_ready_o, 1'b1);
        isu_sc_valid_i          = 1'b1;
        isu_sc_opcode_i         = v.op;
        isu_sc_set_way_offset_i = v.swo;
        dirty0                  = v.dt0;
        dirty1                  = v.dt1;
        wd0                     = v.d0;
        wd1                     = v.d1;
        isu_sc_channel_id_i     = ch;
        isu_sc_xbar_rob_num_i   = rob;
        isu_sc_wbuffer_id_i     = wb;
        tick;
        isu_sc_valid_i          = 1'b0;
        isu_sc_opcode_i         = OP_LINEFILL;
        isu_sc_set_way_offset_i = ~v.swo;
        dirty0                  = 2'b11;
        dirty1                  = 2'b11;
        wd0                     = '1;
        wd1                     = '1;
        isu_sc_channel_id_i     = ~ch;
        isu_sc_xbar_rob_num_i   = ~rob;
        isu_sc_wbuffer_id_i     = ~wb;
    endtask

    task automatic run_vec(input vec_t v, input int i);
        logic [1:0] ch  = 2'(i);
        logic [2:0] rob = 3'(i + 1);
        logic [7:0] wb  = 8'(8'h40 + i);
        send(v, ch, rob, wb);
        if (v.op == OP_READ) begin
            for (int k = 1; k <= 3; k++) begin
                chk($sformatf("v%0d_nrsp_t%0d", i, k), sc_xbar_valid_o, 1'b0);
                tick;
            end
            chk($sformatf("v%0d_b0_valid", i), sc_xbar_valid_o, 1'b1);
            chk($sformatf("v%0d_b0_data", i), sc_xbar_data_o, v.d0);
            chk($sformatf("v%0d_b0_last", i), sc_xbar_last_o, 1'b0);
            chk($sformatf("v%0d_echo", i), {sc_xbar_channel_id_o, sc_xbar_rob_num_o, sc_xbar_wbuffer_id_o}, {ch, rob, wb});
            chk($sformatf("v%0d_busy", i), isu_sc_ready_o, 1'b0);
            tick;
            chk($sformatf("v%0d_b1_valid", i), sc_xbar_valid_o, 1'b1);
            chk($sformatf("v%0d_b1_data", i), sc_xbar_data_o, v.d1);
            chk($sformatf("v%0d_b1_last", i), sc_xbar_last_o, 1'b1);
            tick;
            chk($sformatf("v%0d_done", i), {isu_sc_ready_o, sc_xbar_valid_o}, 2'b10);
        end else if (v.op == OP_WRITE || v.op == OP_LINEFILL) begin
            chk($sformatf("v%0d_wr_t1", i), {isu_sc_ready_o, sc_xbar_valid_o}, 2'b00);
            tick;
            chk($sformatf("v%0d_wr_t2", i), {isu_sc_ready_o, sc_xbar_valid_o}, 2'b00);
            tick;
            chk($sformatf("v%0d_wr_t3", i), {isu_sc_ready_o, sc_xbar_valid_o}, 2'b10);
        end else begin
            chk($sformatf("v%0d_rsv_t1", i), {isu_sc_ready_o, sc_xbar_valid_o}, 2'b00);
            tick;
            chk($sformatf("v%0d_rsv_t2", i), {isu_sc_ready_o, sc_xbar_valid_o}, 2'b10);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vecs[0]  = '{OP_LINEFILL, 7'd4,   2'b00, 2'b00, 128'd100, 128'd101};
        vecs[1]  = '{OP_READ,     7'd4,   2'b00, 2'b00, 128'd100, 128'd101};
        vecs[2]  = '{OP_WRITE,    7'd4,   2'b00, 2'b10, 128'd999, 128'd7};
        vecs[3]  = '{OP_READ,     7'd5,   2'b00, 2'b00, 128'd100, 128'd7};
        vecs[4]  = '{OP_LINEFILL, 7'd126, 2'b00, 2'b00, {4{32'hA5A5_0001}}, {4{32'h5A5A_0002}}};
        vecs[5]  = '{OP_WRITE,    7'd0,   2'b01, 2'b11, 128'd11,  128'd22};
        vecs[6]  = '{OP_READ,     7'd127, 2'b00, 2'b00, {4{32'hA5A5_0001}}, {4{32'h5A5A_0002}}};
        vecs[7]  = '{OP_READ,     7'd0,   2'b00, 2'b00, 128'd11,  128'd22};
        vecs[8]  = '{3'd5,        7'd4,   2'b11, 2'b11, 128'd55,  128'd66};
        vecs[9]  = '{OP_READ,     7'd4,   2'b00, 2'b00, 128'd100, 128'd7};
        vecs[10] = '{OP_WRITE,    7'd1,   2'b10, 2'b00, 128'd33,  128'd44};
        vecs[11] = '{3'd7,        7'd0,   2'b11, 2'b11, 128'd77,  128'd88};
        vecs[12] = '{OP_READ,     7'd0,   2'b00, 2'b00, 128'd33,  128'd22};

        tick;
        tick;
        chk("rst_ready", isu_sc_ready_o, 1'b0);
        chk("rst_valid", sc_xbar_valid_o, 1'b0);
        chk("rst_last", sc_xbar_last_o, 1'b0);
        chk("rst_data", sc_xbar_data_o, '0);
        chk("rst_echo", {sc_xbar_channel_id_o, sc_xbar_rob_num_o, sc_xbar_wbuffer_id_o}, 13'd0);
`ifdef BANK_SC_PERF_CNT_EN
        chk("rst_cnt", {sc_rd_cnt_o, sc_wr_cnt_o}, 32'd0);
`endif
        rst_i = 1'b1;
        chk("rel_ready_low", isu_sc_ready_o, 1'b0);
        tick;
        chk("rel_ready_high", isu_sc_ready_o, 1'b1);

        for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

        // Back-pressure: line 4 holds {100, 7}
        v = '{OP_READ, 7'd4, 2'b00, 2'b00, 128'd0, 128'd0};
        sc_xbar_ready_i = 1'b0;
        send(v, 2'd3, 3'd6, 8'hC3);
        tick;
        tick;
        tick;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("stall%0d_valid", k), sc_xbar_valid_o, 1'b1);
            chk($sformatf("stall%0d_data", k), sc_xbar_data_o, 128'd100);
            chk($sformatf("stall%0d_rob", k), sc_xbar_rob_num_o, 3'd6);
            chk($sformatf("stall%0d_last", k), sc_xbar_last_o, 1'b0);
            chk($sformatf("stall%0d_busy", k), isu_sc_ready_o, 1'b0);
            tick;
        end
        sc_xbar_ready_i = 1'b1;
        tick;
        chk("stall_b1_data", sc_xbar_data_o, 128'd7);
        chk("stall_b1_last", {sc_xbar_valid_o, sc_xbar_last_o}, 2'b11);
        tick;
        chk("stall_done", {isu_sc_ready_o, sc_xbar_valid_o}, 2'b10);

        // Reset while beat 0 is on the bus
        v = '{OP_READ, 7'd0, 2'b00, 2'b00, 128'd0, 128'd0};
        send(v, 2'd2, 3'd5, 8'h99);
        tick;
        tick;
        tick;
        chk("mid_b0_valid", sc_xbar_valid_o, 1'b1);
        chk("mid_b0_data", sc_xbar_data_o, 128'd33);
        rst_i = 1'b0;
        tick;
        chk("mid_rst_valid", sc_xbar_valid_o, 1'b0);
        chk("mid_rst_ready", isu_sc_ready_o, 1'b0);
        chk("mid_rst_out", {sc_xbar_last_o, sc_xbar_rob_num_o, sc_xbar_data_o}, '0);
        rst_i = 1'b1;
        tick;
        chk("mid_rel_ready", isu_sc_ready_o, 1'b1);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("mid_nostale%0d", k), sc_xbar_valid_o, 1'b0);
            tick;
        end

        // Counters restart from reset: 3 reads and 2 linefills
        run_vec(vecs[0], 20);
        run_vec(vecs[1], 21);
        run_vec(vecs[4], 22);
        run_vec(vecs[6], 23);
        run_vec(vecs[12], 24);
`ifdef BANK_SC_PERF_CNT_EN
        chk("perf_rd_cnt", sc_rd_cnt_o, 16'd3);
        chk("perf_wr_cnt", sc_wr_cnt_o, 16'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bank_sc.md
BANK_SC -- requirements
Module: bank_sc

Interface
REQ-001 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_i  input  1  synchronous, active-low reset; sampled on clk_i rising edge.
REQ-003 isu_sc_valid_i  input  1  request valid from issue unit.
REQ-004 isu_sc_ready_o  output  1  request accepted when valid and ready are both high.
REQ-005 isu_sc_channel_id_i  input  2  requesting channel.
REQ-006 isu_sc_opcode_i  input  3  0=WRITE, 1=READ, 2=LINEFILL, 3..7=reserved.
REQ-007 isu_sc_set_way_offset_i  input  7  cacheline address; bit 0 ignored.
REQ-008 isu_sc_wbuffer_id_i  input  8  write-buffer tag, echoed on the response.
REQ-009 isu_sc_xbar_rob_num_i  input  3  crossbar ROB slot, echoed on the response.
REQ-010 isu_sc_cacheline_dirty_offset0_i / _offset1_i  input  2 each  per-offset state; 2'b00=empty.
REQ-011 isu_sc_linefill_data_offset0_i / _offset1_i  input  128 each  write data per offset.
REQ-012 sc_xbar_valid_o  output  1  read response beat valid.
REQ-013 sc_xbar_ready_i  input  1  response beat consumed when valid and ready are both high.
REQ-014 sc_xbar_channel_id_o 2, sc_xbar_rob_num_o 3, sc_xbar_wbuffer_id_o 8  output  echoed request fields.
REQ-015 sc_xbar_data_o  output  128  beat data; sc_xbar_last_o  output  1  high on beat 1.

Function
REQ-016 The data array SHALL hold 128 x 128 bits; offset0 of a line SHALL sit at {swo[6:1],1'b0} and offset1 at {swo[6:1],1'b1}.
REQ-017 The FSM SHALL have states IDLE, WR0, WR1, RD0, RD1, RDW, RSP0 and RSP1.
REQ-018 isu_sc_ready_o SHALL be registered and high only in IDLE.
REQ-019 On acceptance in cycle T, all request fields SHALL be captured into holding registers; the inputs are then don't-care.
REQ-020 WRITE: WR0 (T+1) SHALL write offset0 iff dirty_offset0 != 0; WR1 (T+2) SHALL write offset1 iff dirty_offset1 != 0; the FSM SHALL return to IDLE with ready high at T+3.
REQ-021 LINEFILL SHALL follow the WRITE timing and SHALL write both offsets unconditionally.
REQ-022 WRITE and LINEFILL SHALL produce no response.
REQ-023 READ: RD0 (T+1) SHALL read offset0; RD1 (T+2) SHALL read offset1 and capture offset0; RDW (T+3) SHALL capture offset1; RSP0 SHALL begin at T+4.
REQ-024 RSP0 SHALL drive valid=1, data=offset0 and last=0, and SHALL hold all response outputs stable until ready; RSP1 SHALL follow with data=offset1 and last=1.
REQ-025 The handshake of RSP1 SHALL return the FSM to IDLE, so best-case read occupancy is 6 cycles.
REQ-026 A reserved opcode SHALL be accepted, SHALL make no array access and no response, and SHALL leave ready low for exactly 1 cycle.
REQ-027 The array read latency SHALL be 1 cycle.
REQ-028 The array SHALL have a single port, so no read/write conflict can arise.
REQ-029 Back-pressure from sc_xbar_ready_i SHALL stall the FSM indefinitely with no data loss.

Reset
REQ-030 While rst_i=0, the FSM SHALL go to IDLE and isu_sc_ready_o, sc_xbar_valid_o, sc_xbar_last_o and all echoed fields SHALL be 0.
REQ-031 sc_xbar_data_o and the counters SHALL reset to 0.
REQ-032 Reset mid-operation SHALL drop the in-flight request; array contents are not reset.
REQ-033 isu_sc_ready_o SHALL first be high in the cycle after rst_i returns to 1.

Configuration
REQ-034 With BANK_SC_PERF_CNT_EN defined, the block SHALL add outputs sc_rd_cnt_o[15:0] and sc_wr_cnt_o[15:0].
REQ-035 sc_rd_cnt_o SHALL count accepted READs, sc_wr_cnt_o SHALL count accepted WRITE and LINEFILL requests, and both SHALL saturate at 16'hFFFF.
REQ-036 Without BANK_SC_PERF_CNT_EN, these ports and registers SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-037 A shared package SHALL define the opcode constants, FSM state encoding, data width (128) and array depth (128).
REQ-038 Sub-module bank_sc_ram SHALL implement a 1-port synchronous array with write enable and registered read data.

Verification
REQ-039 LINEFILL swo=4, d0=100, d1=101, then READ swo=4 -> beat0 data=100 last=0 at T+4; beat1 data=101 last=1.
REQ-040 WRITE swo=4, dirty0=2'b00, dirty1=2'b10, d1=7 after the REQ-039 linefill; READ -> beats 100, 7.
REQ-041 READ with sc_xbar_ready_i held low 10 cycles -> valid, data and rob_num stable throughout; isu_sc_ready_o stays low.
REQ-042 Opcode 5 -> ready low for 1 cycle; no response; array unchanged.
REQ-043 rst_i=0 during RSP0 -> next cycle valid=0 and state IDLE; ready=1 the cycle after release; no stale beat.
REQ-044 With BANK_SC_PERF_CNT_EN: 3 READs plus 2 LINEFILLs -> rd_cnt=3, wr_cnt=2; counter preloaded to 16'hFFFE plus 3 accepts -> 16'hFFFF.
